// File: rtl/chicken_pkg.sv
// Shared types, sizes and face/placement helpers for the Chicken Cha-Cha-Cha datapath.
package chicken_pkg;

    localparam int unsigned N_TILES     = 12;
    localparam int unsigned TILE_STRIDE = 5;
    localparam int unsigned CARD_STRIDE = 7;
    localparam int unsigned LAPS        = 1;
    localparam int unsigned MAX_PLAYERS = 4;
    localparam int unsigned FACE_W      = 4;
    localparam int unsigned POS_W       = 4;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned KEY_W       = 4;
    localparam int unsigned NP_W        = 3;
    localparam int unsigned CUR_W       = 2;
    localparam int unsigned LAP_W       = 2;

    typedef enum logic [2:0] {
        ST_SETUP   = 3'b000,
        ST_PLAYERS = 3'b001,
        ST_PLACE   = 3'b010,
        ST_PICK    = 3'b011,
        ST_EVAL    = 3'b100,
        ST_PASS    = 3'b101,
        ST_CHECK   = 3'b110,
        ST_END     = 3'b111
    } state_e;

    // Shuffled tile face for ring slot idx.
    function automatic logic [FACE_W-1:0] tile_face(input logic [IDX_W-1:0] idx,
                                                    input logic [IDX_W-1:0] seed);
        logic [7:0] sum;
        sum = 8'(idx) * 8'(TILE_STRIDE) + 8'(seed);
        tile_face = FACE_W'(sum % 8'(N_TILES)) + FACE_W'(1);
    endfunction

    // Card face for a keypad code; 0 marks a card that can never match.
    function automatic logic [FACE_W-1:0] card_face(input logic [KEY_W-1:0] key);
        logic [7:0] prod;
        prod = (8'(key) - 8'd1) * 8'(CARD_STRIDE);
        if (key == '0 || 32'(key) > N_TILES)
            card_face = '0;
        else
            card_face = FACE_W'(prod % 8'(N_TILES)) + FACE_W'(1);
    endfunction

    // Starting tile of a player: evenly spaced around the ring.
    function automatic logic [POS_W-1:0] place_pos(input logic [IDX_W-1:0] idx,
                                                   input logic [NP_W-1:0]  np);
        logic [7:0] spacing;
        spacing   = (np == '0) ? 8'd0 : 8'(N_TILES / 32'(np));
        place_pos = POS_W'(8'(idx) * spacing);
    endfunction

endpackage

// File: rtl/chicken_tile_ram.sv
// Tile ring storage: one synchronous write port, one asynchronous read port, no reset.
module chicken_tile_ram
    import chicken_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [FACE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [FACE_W-1:0] rdata_o
);

    logic [FACE_W-1:0] mem_q [N_TILES];

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/chicken_datapath.sv
// Game datapath driven by the control FSM state code: tile ring, cards, players, laps and
// the c/go/win status flags returned to the FSM.
module chicken_datapath
    import chicken_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key,
    input  logic [2:0]        M,
    input  logic              A,
    input  logic              WR,
    output logic              c,
    output logic              go,
    output logic              win,
    output logic [NP_W-1:0]   num_players,
    output logic [CUR_W-1:0]  cur_player,
    output logic [POS_W-1:0]  cur_pos,
    output logic [FACE_W-1:0] ahead_face,
    output logic              game_over
);

    state_e st;

    logic [IDX_W-1:0]  seed_cnt_q, seed_cnt_d;
    logic [IDX_W-1:0]  seed_q, seed_d;
    logic              seed_arm_q, seed_arm_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NP_W-1:0]   np_q, np_d;
    logic [CUR_W-1:0]  cur_q, cur_d;
    logic [FACE_W-1:0] card_q, card_d;
    logic [POS_W-1:0]  pos_q [MAX_PLAYERS];
    logic [POS_W-1:0]  pos_d [MAX_PLAYERS];
    logic [LAP_W-1:0]  laps_q [MAX_PLAYERS];
    logic [LAP_W-1:0]  laps_d [MAX_PLAYERS];
    logic              game_over_q;

    logic [IDX_W-1:0]  seed_eff;
    logic              tile_we;
    logic [4:0]        ahead_sum;
    logic [POS_W-1:0]  ahead_idx;
    logic [POS_W-1:0]  start_pos;

    assign st        = state_e'(M);
    assign seed_eff  = seed_arm_q ? seed_cnt_q : seed_q;
    assign tile_we   = (st == ST_SETUP) && WR && (idx_q < IDX_W'(N_TILES));
    assign cur_pos   = pos_q[cur_q];
    assign ahead_sum = 5'(cur_pos) + 5'd1;
    assign ahead_idx = (ahead_sum >= 5'(N_TILES)) ? POS_W'(ahead_sum - 5'(N_TILES))
                                                  : POS_W'(ahead_sum);
    assign start_pos = place_pos(IDX_W'(cur_q), np_q);

    chicken_tile_ram u_tile_ram (
        .clk     (clk),
        .we_i    (tile_we),
        .waddr_i (idx_q),
        .wdata_i (tile_face(idx_q, seed_eff)),
        .raddr_i (IDX_W'(ahead_idx)),
        .rdata_o (ahead_face)
    );

    // Status flags decoded from the current FSM state and register contents.
    assign c   = ((st == ST_SETUP) && (idx_q == IDX_W'(N_TILES))) ||
                 ((st == ST_PLACE) && (np_q != '0) && (idx_q == IDX_W'(np_q)));
    assign go  = (st == ST_EVAL) && (card_q != '0) && (card_q == ahead_face);
    assign win = (st == ST_CHECK) && (laps_q[cur_q] == LAP_W'(LAPS));

    assign num_players = np_q;
    assign cur_player  = cur_q;
    assign game_over   = game_over_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_cnt_q  <= '0;
            seed_q      <= '0;
            seed_arm_q  <= 1'b1;
            idx_q       <= '0;
            np_q        <= '0;
            cur_q       <= '0;
            card_q      <= '0;
            game_over_q <= 1'b0;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                pos_q[i]  <= '0;
                laps_q[i] <= '0;
            end
        end else begin
            seed_cnt_q  <= seed_cnt_d;
            seed_q      <= seed_d;
            seed_arm_q  <= seed_arm_d;
            idx_q       <= idx_d;
            np_q        <= np_d;
            cur_q       <= cur_d;
            card_q      <= card_d;
            game_over_q <= (st == ST_END);
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                pos_q[i]  <= pos_d[i];
                laps_q[i] <= laps_d[i];
            end
        end
    end

    always_comb begin
        seed_cnt_d = (seed_cnt_q == IDX_W'(N_TILES - 1)) ? '0 : seed_cnt_q + IDX_W'(1);
        seed_d     = seed_q;
        seed_arm_d = seed_arm_q;
        idx_d      = idx_q;
        np_d       = np_q;
        cur_d      = cur_q;
        card_d     = card_q;
        pos_d      = pos_q;
        laps_d     = laps_q;

        case (st)
            ST_SETUP: begin
                if (seed_arm_q) begin
                    seed_d     = seed_cnt_q;
                    seed_arm_d = 1'b0;
                end
                if (tile_we)
                    idx_d = idx_q + IDX_W'(1);
            end
            ST_PLAYERS: begin
                if (key >= KEY_W'(2) && key <= KEY_W'(MAX_PLAYERS)) begin
                    np_d  = NP_W'(key);
                    idx_d = '0;
                end
            end
            ST_PLACE: begin
                cur_d = '0;
                if (idx_q < IDX_W'(np_q)) begin
                    pos_d[CUR_W'(idx_q)]  = place_pos(idx_q, np_q);
                    laps_d[CUR_W'(idx_q)] = '0;
                    idx_d                 = idx_q + IDX_W'(1);
                end
            end
            ST_PICK: begin
                if (A && key != '0)
                    card_d = card_face(key);
            end
            ST_EVAL: begin
                // A match advances the player; a miss hands the turn on.
                if (go) begin
                    pos_d[cur_q] = ahead_idx;
                    if (ahead_idx == start_pos && laps_q[cur_q] < LAP_W'(LAPS))
                        laps_d[cur_q] = laps_q[cur_q] + LAP_W'(1);
                end else if (NP_W'(cur_q) + NP_W'(1) >= np_q) begin
                    cur_d = '0;
                end else begin
                    cur_d = cur_q + CUR_W'(1);
                end
                card_d = '0;
            end
            ST_END: begin
                seed_cnt_d = seed_cnt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chicken_datapath.sv
// Directed bench for chicken_datapath with a game-rule model compared on every falling edge.
module tb_chicken_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [2:0] M;
    logic       A;
    logic       WR;
    logic       c, go, win, game_over;
    logic [2:0] num_players;
    logic [1:0] cur_player;
    logic [3:0] cur_pos, ahead_face;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    chicken_datapath dut (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .M           (M),
        .A           (A),
        .WR          (WR),
        .c           (c),
        .go          (go),
        .win         (win),
        .num_players (num_players),
        .cur_player  (cur_player),
        .cur_pos     (cur_pos),
        .ahead_face  (ahead_face),
        .game_over   (game_over)
    );

    // Game-rule model
    int m_cyc, m_seed, m_idx, m_np, m_cur, m_card;
    bit m_arm, m_over;
    int m_tile  [12];
    bit m_known [12];
    int m_pos   [4];
    int m_start [4];
    int m_laps  [4];

    function automatic int card_of(input int k);
        if (k == 0 || k > 12) return 0;
        return ((k - 1) * 7) % 12 + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0; m_arm = 1'b1; m_seed = 0; m_idx = 0; m_np = 0;
        m_cur = 0; m_card = 0; m_over = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_pos[i] = 0; m_start[i] = 0; m_laps[i] = 0;
        end
    endtask

    task automatic model_step();
        int  ai;
        bit  hit;
        ai  = (m_pos[m_cur] + 1) % 12;
        hit = (m_card != 0) && m_known[ai] && (m_card == m_tile[ai]);
        case (M)
            3'd0: begin
                if (m_arm) begin m_seed = m_cyc % 12; m_arm = 1'b0; end
                if (WR && m_idx < 12) begin
                    m_tile[m_idx]  = (m_idx * 5 + m_seed) % 12 + 1;
                    m_known[m_idx] = 1'b1;
                    m_idx++;
                end
            end
            3'd1: if (key >= 2 && key <= 4) begin m_np = int'(key); m_idx = 0; end
            3'd2: begin
                m_cur = 0;
                if (m_idx < m_np) begin
                    m_pos[m_idx]   = m_idx * (12 / m_np);
                    m_start[m_idx] = m_pos[m_idx];
                    m_laps[m_idx]  = 0;
                    m_idx++;
                end
            end
            3'd3: if (A && key != 0) m_card = card_of(int'(key));
            3'd4: begin
                if (hit) begin
                    m_pos[m_cur] = ai;
                    if (ai == m_start[m_cur] && m_laps[m_cur] < 1) m_laps[m_cur]++;
                end else if (m_np != 0) begin
                    m_cur = (m_cur + 1) % m_np;
                end
                m_card = 0;
            end
            default: ;
        endcase
        m_over = (M == 3'd7);
        if (M != 3'd7) m_cyc++;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    always @(negedge clk) begin : cmp
        int ai;
        ai = (m_pos[m_cur] + 1) % 12;
        if (cmp_en && rst) begin
            chk("c",   c,   (M == 3'd0 && m_idx == 12) || (M == 3'd2 && m_np != 0 && m_idx == m_np));
            chk("go",  go,  M == 3'd4 && m_card != 0 && m_known[ai] && m_card == m_tile[ai]);
            chk("win", win, M == 3'd6 && m_laps[m_cur] == 1);
            chk("num_players", num_players, m_np);
            chk("cur_player",  cur_player,  m_cur);
            chk("cur_pos",     cur_pos,     m_pos[m_cur]);
            chk("game_over",   game_over,   m_over);
            if (m_known[ai]) chk("ahead_face", ahead_face, m_tile[ai]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [3:0] k, input logic a, input logic w);
        M = m; key = k; A = a; WR = w;
        tick();
    endtask

    task automatic do_setup();
        drive(3'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(3'd0, 4'd0, 1'b0, 1'b1);
            if (i == 10) chk("setup_c_early", c, 0);
        end
        chk("setup_c_done", c, 1);
        drive(3'd0, 4'd0, 1'b0, 1'b1);
        chk("setup_c_hold", c, 1);
    endtask

    // One PICK with key k, then EVAL with an expected go value.
    task automatic pick_eval(input string name, input int k, input logic exp_go);
        drive(3'd3, 4'(k), 1'b1, 1'b0);
        M = 3'd4; key = 4'd0; A = 1'b0;
        #1;
        chk(name, go, exp_go);
        tick();
    endtask

    initial begin
        int f, k;
        rst = 1'b0; M = 3'd0; key = 4'd0; A = 1'b0; WR = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c", c, 0);
        chk("rst_go", go, 0);
        chk("rst_win", win, 0);
        chk("rst_np", num_players, 0);
        chk("rst_cur", cur_player, 0);
        chk("rst_pos", cur_pos, 0);
        chk("rst_over", game_over, 0);
        rst = 1'b1; cmp_en = 1'b1;

        do_setup();
        drive(3'd1, 4'd1, 1'b0, 1'b0);
        chk("key1_ignored", num_players, 0);
        drive(3'd1, 4'd3, 1'b0, 1'b0);
        drive(3'd1, 4'd6, 1'b0, 1'b0);
        chk("np_three", num_players, 3);

        // Reset in the middle of PLACE
        drive(3'd2, 4'd0, 1'b0, 1'b0);
        drive(3'd2, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rst_c", c, 0);
        chk("mid_rst_np", num_players, 0);
        chk("mid_rst_cur", cur_player, 0);
        chk("mid_rst_pos", cur_pos, 0);
        chk("mid_rst_over", game_over, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("post_rst_c", c, 0);

        do_setup();
        drive(3'd1, 4'd3, 1'b0, 1'b0);
        drive(3'd2, 4'd0, 1'b0, 1'b0);
        drive(3'd2, 4'd0, 1'b0, 1'b0);
        chk("place_c_early", c, 0);
        drive(3'd2, 4'd0, 1'b0, 1'b0);
        chk("place_c_done", c, 1);
        chk("place_pos0", cur_pos, 0);
        chk("ahead_tile1", ahead_face, 6);

        // Misses rotate the turn through three players
        pick_eval("miss_p0", 2, 1'b0);
        drive(3'd5, 4'd0, 1'b0, 1'b0);
        chk("p1_turn", cur_player, 1);
        chk("p1_pos", cur_pos, 4);
        pick_eval("miss_p1", 2, 1'b0);
        drive(3'd6, 4'd0, 1'b0, 1'b0);
        chk("p2_turn", cur_player, 2);
        chk("p2_pos", cur_pos, 8);
        chk("ahead_tile9", ahead_face, 10);
        pick_eval("miss_p2", 2, 1'b0);
        drive(3'd5, 4'd0, 1'b0, 1'b0);
        chk("turn_wrap", cur_player, 0);

        // Two players; player 0 walks a full lap
        drive(3'd1, 4'd2, 1'b0, 1'b0);
        chk("np_two", num_players, 2);
        drive(3'd2, 4'd0, 1'b0, 1'b0);
        drive(3'd2, 4'd0, 1'b0, 1'b0);
        chk("place2_c", c, 1);
        for (int s = 0; s < 12; s++) begin
            f = m_tile[(m_pos[m_cur] + 1) % 12];
            k = 0;
            for (int j = 1; j <= 12; j++) if (card_of(j) == f) k = j;
            pick_eval("lap_go", k, 1'b1);
            M = 3'd6;
            #1;
            chk("lap_win", win, s == 11);
            chk("lap_pos", cur_pos, (s + 1) % 12);
            tick();
        end

        // Out-of-range key never matches, then END freezes everything
        pick_eval("key13_go", 13, 1'b0);
        chk("key13_cur", cur_player, 1);
        chk("key13_pos", cur_pos, 6);
        drive(3'd7, 4'd0, 1'b0, 1'b0);
        chk("end_over", game_over, 1);
        drive(3'd7, 4'd3, 1'b1, 1'b1);
        drive(3'd7, 4'd2, 1'b1, 1'b0);
        chk("end_cur", cur_player, 1);
        chk("end_pos", cur_pos, 6);
        chk("end_np", num_players, 2);
        chk("end_over_hold", game_over, 1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
